// File: rtl/shifter_8bit.sv
// Registered 8-bit barrel rotator: rotates the operand left or right by 0-7
// positions with one cycle of latency.
module shifter_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [2:0] s,
    input  logic       lr,
    output logic [7:0] y
);

    logic [7:0] left_1;
    logic [7:0] left_2;
    logic [7:0] left_4;
    logic [7:0] right_1;
    logic [7:0] right_2;
    logic [7:0] right_4;
    logic [7:0] rot_result;

    // Two independent log-stage chains; the direction mux sits after the last stage.
    always_comb begin
        left_1  = s[0] ? {a[6:0], a[7]}           : a;
        left_2  = s[1] ? {left_1[5:0], left_1[7:6]} : left_1;
        left_4  = s[2] ? {left_2[3:0], left_2[7:4]} : left_2;

        right_1 = s[0] ? {a[0], a[7:1]}             : a;
        right_2 = s[1] ? {right_1[1:0], right_1[7:2]} : right_1;
        right_4 = s[2] ? {right_2[3:0], right_2[7:4]} : right_2;

        rot_result = lr ? right_4 : left_4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= 8'h00;
        end else begin
            y <= rot_result;
        end
    end

endmodule

// File: tb/tb_shifter_8bit.sv
// Self-checking bench for shifter_8bit: expected values are queued when
// stimulus is driven and popped when the registered result appears.
module tb_shifter_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [2:0] s;
    logic       lr;
    logic [7:0] y;

    int checks;
    int fails;
    logic [7:0] exp_q[$];

    shifter_8bit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .s   (s),
        .lr  (lr),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the mod-8 index equations.
    function automatic logic [7:0] rot_model(input logic [7:0] av, input logic [2:0] sv,
                                             input logic lv);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (lv)
                r[i] = av[(i + int'(sv)) % 8];
            else
                r[i] = av[(i - int'(sv) + 8) % 8];
        end
        return r;
    endfunction

    // Drives one operation on the falling edge, queues its expected result,
    // then returns that expectation just after the next rising edge.
    task automatic drive(input logic r, input logic [7:0] av, input logic [2:0] sv,
                         input logic lv, input logic [7:0] ev, output logic [7:0] eo);
        @(negedge clk);
        rst = r;
        a   = av;
        s   = sv;
        lr  = lv;
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        eo = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'hFF, 3'd3, 1'b0, 8'h00, e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", k, y, e);
            end
        end
        drive(1'b0, 8'hFF, 3'd3, 1'b0, 8'hFF, e);
        checks++;
        if (y !== e) begin
            fails++;
            $display("[TB] FAIL reset_release: got %h expected %h", y, e);
        end
    endtask

    task automatic test_left_sweep();
        logic [7:0] table_l[8] = '{8'h24, 8'h48, 8'h90, 8'h21, 8'h42, 8'h84, 8'h09, 8'h12};
        logic [7:0] e;
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, 8'h24, 3'(n), 1'b0, table_l[n], e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL left_sweep s=%0d: got %h expected %h", n, y, e);
            end
        end
    endtask

    task automatic test_right_sweep();
        logic [7:0] table_r[8] = '{8'h24, 8'h12, 8'h09, 8'h84, 8'h42, 8'h21, 8'h90, 8'h48};
        logic [7:0] e;
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, 8'h24, 3'(n), 1'b1, table_r[n], e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL right_sweep s=%0d: got %h expected %h", n, y, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wa[3] = '{8'h80, 8'h01, 8'h81};
        logic [2:0] ws[3] = '{3'd1, 3'd1, 3'd7};
        logic       wl[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] wy[3] = '{8'h01, 8'h80, 8'h03};
        logic [7:0] e;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, wa[k], ws[k], wl[k], wy[k], e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL wrap case %0d: got %h expected %h", k, y, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dy[4] = '{8'h96, 8'h69, 8'h96, 8'h69};
        logic [7:0] e;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'hA5, 3'd2, 1'(k % 2), dy[k], e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL dir_toggle step %0d: got %h expected %h", k, y, e);
            end
        end
    endtask

    task automatic test_no_comb_path();
        logic [7:0] e;
        drive(1'b0, 8'h3C, 3'd1, 1'b0, 8'h78, e);
        a  = 8'hC3;
        s  = 3'd5;
        lr = 1'b1;
        #2;
        checks++;
        if (y !== e) begin
            fails++;
            $display("[TB] FAIL no_comb_path: got %h expected %h", y, e);
        end
    endtask

    task automatic test_midstream_reset();
        logic [7:0] e;
        for (int n = 0; n < 8; n++) begin
            if (n == 3)
                drive(1'b1, 8'h24, 3'(n), 1'b0, 8'h00, e);
            else
                drive(1'b0, 8'h24, 3'(n), 1'b0, rot_model(8'h24, 3'(n), 1'b0), e);
            checks++;
            if (y !== e) begin
                fails++;
                $display("[TB] FAIL midstream_reset s=%0d: got %h expected %h", n, y, e);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] e;
        for (int av = 0; av < 256; av++) begin
            for (int sv = 0; sv < 8; sv++) begin
                for (int lv = 0; lv < 2; lv++) begin
                    drive(1'b0, 8'(av), 3'(sv), 1'(lv), rot_model(8'(av), 3'(sv), 1'(lv)), e);
                    checks++;
                    if (y !== e) begin
                        fails++;
                        $display("[TB] FAIL exhaustive a=%h s=%0d lr=%0d: got %h expected %h",
                                 av[7:0], sv, lv, y, e);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        a      = 8'hFF;
        s      = 3'd3;
        lr     = 1'b0;
        test_reset();
        test_left_sweep();
        test_right_sweep();
        test_wrap();
        test_back_to_back();
        test_no_comb_path();
        test_midstream_reset();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
